sensor_packetizer: RTL and testbench
====================================

SENSOR_PACKETIZER -- requirements
Module: sensor_packetizer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, sample buffer depth; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe; sensor_id and sample are valid this cycle.
REQ-006 SHALL have port sensor_id  input  4  source sensor number.
REQ-007 SHALL have port sample  input  16  sensor reading.
REQ-008 SHALL have port tx_start  output  1  one-cycle pulse to the downstream UART transmitter.
REQ-009 SHALL have port tx_data  output  8  byte to transmit; held stable from the tx_start pulse until the next pulse.
REQ-010 SHALL have port tx_busy  input  1  transmitter busy; it rises the cycle after tx_start and falls when the byte is done.
REQ-011 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  number of buffered samples.
REQ-012 SHALL have port drop_cnt  output  8  saturating count of dropped samples.
REQ-013 SHALL have port idle  output  1  high when the FIFO is empty and the FSM is in IDLE.

Function
REQ-014 SHALL write {sensor_id, sample} into the FIFO on a clock edge where sample_valid=1 and the FIFO is not full.
REQ-015 SHALL accept a write to a full FIFO when a pop occurs on the same edge; fifo_level is unchanged in that case.
REQ-016 SHALL drop a sample offered to a full FIFO with no pop on that edge, and SHALL increment drop_cnt; drop_cnt saturates at 255 and never wraps.
REQ-017 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH and SHALL keep fifo_level exact through wrap-around.
REQ-018 SHALL send each sample as a 5-byte frame, in order: SYNC_BYTE, {4'h0,id}, sample[15:8], sample[7:0], CSUM.
REQ-019 SHALL compute CSUM = ({4'h0,id} + sample[15:8] + sample[7:0]) mod 256, with an 8-bit wrap.
REQ-020 SHALL implement a five-state FSM: IDLE, LOAD, SEND, GUARD, WAIT.
REQ-021 SHALL transition IDLE->LOAD when the FIFO is non-empty; the pop happens on this edge.
REQ-022 SHALL, in LOAD, latch the popped entry into a frame register, compute CSUM, clear the byte index to 0, and go to SEND.
REQ-023 SHALL, in SEND with tx_busy=0, drive tx_data with the indexed byte, pulse tx_start for exactly one cycle, and go to GUARD; with tx_busy=1 it stays in SEND.
REQ-024 SHALL spend exactly one cycle in GUARD, ignore tx_busy there, and then go to WAIT.
REQ-025 SHALL, in WAIT with tx_busy=0: go to IDLE if the byte index is 4, otherwise increment the index and go to SEND.
REQ-026 SHALL register tx_start; it is never high on two consecutive cycles.
REQ-027 SHALL, with an empty FIFO, the FSM in IDLE and tx_busy=0, drive tx_start high on the third cycle after the edge that samples sample_valid (latency 3).
REQ-028 SHALL keep accepting and dropping samples during frame transmission; a frame in progress is never aborted.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: tx_start=0, tx_data=8'h00, fifo_level=0, drop_cnt=0, idle=1, FSM=IDLE, byte index=0, FIFO pointers=0.
REQ-030 SHALL discard the buffered samples and any partial frame on a reset asserted mid-frame; after release, no remaining bytes of that frame are sent.
REQ-031 SHALL start a new frame after reset only when a new sample arrives and tx_busy=0.

Verification
REQ-032 Single frame: id=3, sample=16'h1234, transmitter model busy for 10 cycles per byte -> bytes A5,03,12,34,49 in order; 5 tx_start pulses; idle=1 afterwards.
REQ-033 Checksum wrap: id=F, sample=16'hFFFF -> bytes A5,0F,FF,FF,0D.
REQ-034 Overflow: tx_busy held high and 7 back-to-back sample_valid -> first sample popped into the frame register, fifo_level=4, drop_cnt=2; on release, all 5 accepted samples are framed in FIFO order.
REQ-035 Saturation: FIFO full and tx_busy held high, 300 further strobes -> drop_cnt=255.
REQ-036 Reset mid-frame: rst_n low after the 2nd byte of a frame with 2 samples queued -> all outputs at their reset values; after release and one new sample id=1, sample=16'h0001 -> only A5,01,00,01,02 is sent.
REQ-037 Latency and back-pressure: sample into an empty FIFO with tx_busy=0 -> tx_start on cycle 3; tx_busy held high 20 cycles in SEND -> no tx_start until tx_busy=0, then exactly one pulse.

Source files
------------

// File: rtl/sensor_packetizer.sv
// Buffers {sensor_id, sample} pairs in a small FIFO and serialises each one as a
// five-byte frame (sync, id, sample hi, sample lo, checksum) to a byte-wide UART.
//
// state | meaning
// IDLE  | waiting for a buffered sample; pops the FIFO when one is present
// LOAD  | popped entry held; checksum computed, byte index cleared
// SEND  | waiting for tx_busy low, then launches the indexed byte
// GUARD | one-cycle gap while the transmitter raises tx_busy
// WAIT  | waiting for the byte to finish; advances index or returns to IDLE
module sensor_packetizer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_valid,
    input  logic [3:0]                    sensor_id,
    input  logic [15:0]                   sample,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    input  logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_cnt,
    output logic                          idle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   LVL_ONE = 1;
    localparam logic [AW:0]   LVL_FULL = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {IDLE, LOAD, SEND, GUARD, WAIT} state_t;

    state_t        state_q, state_d;
    logic [19:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          empty, full, pop, push, drop, send_fire, idx_inc;
    logic [2:0]    idx_q;
    logic [3:0]    frame_id;
    logic [15:0]   frame_smp;
    logic [7:0]    csum_q, cur_byte;

    assign empty = (fifo_level == '0);
    assign full  = (fifo_level == LVL_FULL);
    // A full FIFO still takes a write when the read side frees a slot on the same edge.
    assign push  = sample_valid && (!full || pop);
    assign drop  = sample_valid && full && !pop;
    assign idle  = empty && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {sensor_id, sample};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        send_fire = 1'b0;
        idx_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = SEND;
            SEND: begin
                if (!tx_busy) begin
                    send_fire = 1'b1;
                    state_d   = GUARD;
                end
            end
            GUARD: state_d = WAIT;
            WAIT: begin
                if (!tx_busy) begin
                    if (idx_q == 3'd4) begin
                        state_d = IDLE;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_byte = SYNC_BYTE;
        case (idx_q)
            3'd1:    cur_byte = {4'h0, frame_id};
            3'd2:    cur_byte = frame_smp[15:8];
            3'd3:    cur_byte = frame_smp[7:0];
            3'd4:    cur_byte = csum_q;
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    // The entry is captured on the pop edge itself: a simultaneous write to a full
    // FIFO lands in the slot just vacated, so reading it a cycle later would be wrong.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            frame_id  <= 4'h0;
            frame_smp <= 16'h0000;
            csum_q    <= 8'h00;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            state_q  <= state_d;
            tx_start <= send_fire;
            if (pop) {frame_id, frame_smp} <= mem[rd_ptr];
            if (state_q == LOAD) begin
                csum_q <= {4'h0, frame_id} + frame_smp[15:8] + frame_smp[7:0];
                idx_q  <= 3'd0;
            end else if (idx_inc) begin
                idx_q <= idx_q + 3'd1;
            end
            if (send_fire) tx_data <= cur_byte;
        end
    end
endmodule

// File: tb/tb_sensor_packetizer.sv
// Randomised and directed bench for sensor_packetizer, checked every cycle against
// a queue-based reference model of the FIFO and frame timing.
module tb_sensor_packetizer;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int A_IDLE = 0, A_SEND = 1, A_DONE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_valid = 1'b0;
    logic [3:0]    sensor_id = 4'h0;
    logic [15:0]   sample = 16'h0000;
    logic          tx_busy = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [LW-1:0] fifo_level;
    logic [7:0]    drop_cnt;
    logic          idle;

    sensor_packetizer #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sensor_id(sensor_id),
        .sample(sample), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt), .idle(idle)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] frame_byte(input logic [19:0] f, input int i);
        int c;
        c = int'(f[19:16]) + int'(f[15:8]) + int'(f[7:0]);
        case (i)
            0:       return SYNC;
            1:       return {4'h0, f[19:16]};
            2:       return f[15:8];
            3:       return f[7:0];
            default: return 8'(c % 256);
        endcase
    endfunction

    // transmitter: busy from the cycle after tx_start for busy_len cycles
    int busy_len = 10;
    bit hold_busy = 1'b0;
    int bcnt = 0;
    always @(negedge clk) begin
        if (tx_start === 1'b1) bcnt = busy_len;
        else if (bcnt > 0) bcnt--;
        tx_busy = hold_busy || (bcnt > 0);
    end

    // reference model
    logic [19:0] mq[$];
    logic [7:0]  log_q[$];
    int          act = A_IDLE, ready = 0, nsent = 0, m_drop = 0, sz0;
    longint      k = 0;
    logic [19:0] mframe = '0;
    logic [7:0]  m_data = 8'h00;
    bit          m_start = 1'b0, m_pop, prev_start = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            k++;
            m_start = 1'b0;
            if (!rst_n) begin
                mq.delete();
                act = A_IDLE; nsent = 0; m_drop = 0; m_data = 8'h00;
            end else begin
                m_pop = 1'b0;
                sz0 = mq.size();
                case (act)
                    A_IDLE: if (sz0 > 0) begin
                        mframe = mq.pop_front();
                        m_pop = 1'b1; act = A_SEND; ready = int'(k) + 2; nsent = 0;
                    end
                    A_SEND: if (k >= ready && !tx_busy) begin
                        m_start = 1'b1; m_data = frame_byte(mframe, nsent);
                        act = A_DONE; ready = int'(k) + 2;
                    end
                    default: if (k >= ready && !tx_busy) begin
                        nsent++;
                        act = (nsent == 5) ? A_IDLE : A_SEND;
                        ready = int'(k) + 1;
                    end
                endcase
                if (sample_valid) begin
                    if (sz0 < DEPTH || m_pop) mq.push_back({sensor_id, sample});
                    else if (m_drop < 255) m_drop++;
                end
            end
            @(negedge clk);
            if (chk_en) begin
                chk("tx_start", tx_start, m_start);
                chk("tx_data", tx_data, m_data);
                chk("fifo_level", fifo_level, mq.size());
                chk("drop_cnt", drop_cnt, m_drop);
                chk("idle", idle, (act == A_IDLE && mq.size() == 0));
                chk("tx_start_twice", tx_start && prev_start, 0);
            end
            prev_start = (tx_start === 1'b1);
            if (tx_start === 1'b1) log_q.push_back(tx_data);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int n = 0;
        while (!(idle === 1'b1 && tx_busy == 1'b0) && n < maxc) begin
            step();
            n++;
        end
        chk(nm, (n < maxc), 1);
    endtask

    task automatic strobe(input logic [3:0] id, input logic [15:0] s);
        sample_valid = 1'b1; sensor_id = id; sample = s;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic check_log(input string nm, input logic [19:0] f);
        chk({nm, "_len"}, log_q.size(), 5);
        for (int i = 0; i < 5; i++)
            chk(nm, (i < log_q.size()) ? {24'h0, log_q[i]} : 32'hFFFF_FFFF, frame_byte(f, i));
    endtask

    task automatic check_lit(input string nm, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input logic [7:0] e4);
        logic [7:0] e[5];
        e = '{e0, e1, e2, e3, e4};
        chk({nm, "_len"}, log_q.size(), 5);
        for (int i = 0; i < 5; i++)
            chk(nm, (i < log_q.size()) ? {24'h0, log_q[i]} : 32'hFFFF_FFFF, e[i]);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_tx_start"}, tx_start, 0);
        chk({nm, "_tx_data"}, tx_data, 8'h00);
        chk({nm, "_level"}, fifo_level, 0);
        chk({nm, "_drop"}, drop_cnt, 0);
        chk({nm, "_idle"}, idle, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] ov[7];
        int pulses, n;
        logic s1, s2, s3, s4;

        repeat (3) step();
        check_reset_vals("reset");
        rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        // single frame
        busy_len = 10; log_q.delete();
        strobe(4'h3, 16'h1234);
        wait_idle("frame1_done", 200);
        check_lit("frame1", 8'hA5, 8'h03, 8'h12, 8'h34, 8'h49);

        // checksum wrap
        log_q.delete();
        strobe(4'hF, 16'hFFFF);
        wait_idle("frame2_done", 200);
        check_lit("csum_wrap", 8'hA5, 8'h0F, 8'hFF, 8'hFF, 8'h0D);

        // latency 3
        busy_len = 2;
        sample_valid = 1'b1; sensor_id = 4'h5; sample = 16'hBEEF;
        step(); sample_valid = 1'b0; s1 = tx_start;
        step(); s2 = tx_start;
        step(); s3 = tx_start;
        step(); s4 = tx_start;
        chk("lat_e1", s1, 0); chk("lat_e2", s2, 0); chk("lat_e3", s3, 0);
        chk("lat_e3_pulse", s4, 1);
        wait_idle("lat_done", 200);

        // back-pressure in SEND
        hold_busy = 1'b1; tx_busy = 1'b1;
        strobe(4'h6, 16'h0102);
        pulses = 0;
        repeat (23) begin step(); if (tx_start === 1'b1) pulses++; end
        chk("bp_no_pulse", pulses, 0);
        hold_busy = 1'b0; tx_busy = (bcnt > 0);
        pulses = 0;
        repeat (3) begin step(); if (tx_start === 1'b1) pulses++; end
        chk("bp_one_pulse", pulses, 1);
        wait_idle("bp_done", 200);

        // overflow
        hold_busy = 1'b1; tx_busy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ov[i] = 20'($urandom);
            sample_valid = 1'b1; {sensor_id, sample} = ov[i];
            step();
        end
        sample_valid = 1'b0;
        chk("ovf_level", fifo_level, 4);
        chk("ovf_drop", drop_cnt, 2);
        log_q.delete();
        hold_busy = 1'b0; tx_busy = (bcnt > 0);
        wait_idle("ovf_done", 1500);
        chk("ovf_bytes", log_q.size(), 25);
        for (int f = 0; f < 5; f++)
            for (int i = 0; i < 5; i++)
                chk("ovf_order", (f*5+i < log_q.size()) ? {24'h0, log_q[f*5+i]} : 32'hFFFF_FFFF,
                    frame_byte(ov[f], i));

        // saturation
        hold_busy = 1'b1; tx_busy = 1'b1;
        sample_valid = 1'b1;
        repeat (305) begin
            {sensor_id, sample} = 20'($urandom);
            step();
        end
        sample_valid = 1'b0;
        chk("sat_drop", drop_cnt, 255);
        chk("sat_level", fifo_level, 4);
        hold_busy = 1'b0; tx_busy = (bcnt > 0);
        wait_idle("sat_done", 1500);

        // reset mid-frame
        busy_len = 10;
        strobe(4'h7, 16'h1111);
        strobe(4'h8, 16'h2222);
        strobe(4'h9, 16'h3333);
        pulses = 0; n = 0;
        while (pulses < 2 && n < 200) begin
            step(); n++;
            if (tx_start === 1'b1) pulses++;
        end
        chk("rst_two_bytes", pulses, 2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        step(); step();
        check_reset_vals("rst_held");
        rst_n = 1'b1;
        log_q.delete();
        repeat (40) step();
        chk("rst_no_resume", log_q.size(), 0);
        strobe(4'h1, 16'h0001);
        wait_idle("rst_new_done", 200);
        check_lit("rst_new", 8'hA5, 8'h01, 8'h00, 8'h01, 8'h02);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 49) == 0) busy_len = $urandom_range(0, 4);
            sample_valid = ($urandom_range(0, 99) < 35);
            {sensor_id, sample} = 20'($urandom);
            step();
        end
        sample_valid = 1'b0;
        wait_idle("rand_done", 3000);
        log_q.delete();
        strobe(4'hC, 16'hA0B0);
        wait_idle("final_done", 200);
        check_log("final_frame", {4'hC, 16'hA0B0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
